// File: rtl/mac_result_accumulator.sv
// MAC result accumulator: buffers incoming MAC results in a small FIFO, sums
// them in groups of len words and presents each group sum with a
// valid/ready handshake. Carry-out of any addition in a group is flagged.
module mac_result_accumulator #(
  parameter int unsigned WIDTH     = 16,
  parameter int unsigned ACC_WIDTH = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned SLACK     = 5
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic [15:0]                  len,
  input  logic [WIDTH-1:0]             in_data,
  input  logic                         in_valid,
  output logic                         almost_full,
  output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
  output logic                         overflow,
  output logic [ACC_WIDTH-1:0]         out_data,
  output logic                         out_ovf,
  output logic                         out_valid,
  input  logic                         out_ready
);

  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW  = 16;
  localparam int unsigned SW  = ACC_WIDTH + 1;
  localparam int unsigned AFT = DEPTH - SLACK;

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e               state_q;
  logic [WIDTH-1:0]     mem_q [DEPTH];
  logic [PW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 almost_full_q;
  logic                 overflow_q;
  logic [ACC_WIDTH-1:0] acc_q;
  logic                 acc_ovf_q;
  logic [LW-1:0]        grp_cnt_q;
  logic [LW-1:0]        len_q;
  logic [ACC_WIDTH-1:0] out_data_q;
  logic                 out_ovf_q;
  logic                 out_valid_q;

  logic                 handshake;
  logic                 pop;
  logic                 full;
  logic                 wr_en;
  logic                 drop;
  logic [WIDTH-1:0]     rd_word;
  logic [LW-1:0]        len_now;
  logic [LW-1:0]        grp_len;
  logic                 grp_last;
  logic [SW-1:0]        sum;

  // Advance a FIFO pointer with wrap-around for any DEPTH.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Datapath decode: pop/write decisions, group boundary and the next sum.
  always_comb begin
    handshake = out_valid_q && out_ready;
    // A handshake in HOLD lets popping resume in the same cycle.
    pop       = ((state_q == ACCUM) || handshake) && (count_q != '0);
    full      = (count_q == CW'(DEPTH));
    wr_en     = in_valid && (!full || pop);
    drop      = in_valid && full && !pop;
    rd_word   = mem_q[rd_ptr_q];
    len_now   = (len == '0) ? LW'(1) : len;
    // len is taken live on the first pop of a group, then held.
    grp_len   = (grp_cnt_q == '0) ? len_now : len_q;
    grp_last  = ((LW + 1)'(grp_cnt_q) + (LW + 1)'(1)) == (LW + 1)'(grp_len);
    sum       = SW'(acc_q) + SW'(rd_word);
    count_d   = count_q + CW'(wr_en) - CW'(pop);
  end

  // FIFO storage; contents need no reset because the pointers are reset.
  always_ff @(posedge clk) begin
    if (wr_en && !clear) begin
      mem_q[wr_ptr_q] <= in_data;
    end
  end

  // Control, accumulator and output registers, including the ACCUM/HOLD FSM.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ACCUM;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      acc_q         <= '0;
      acc_ovf_q     <= 1'b0;
      grp_cnt_q     <= '0;
      len_q         <= LW'(1);
      out_data_q    <= '0;
      out_ovf_q     <= 1'b0;
      out_valid_q   <= 1'b0;
    end else if (clear) begin
      state_q       <= ACCUM;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      almost_full_q <= 1'b0;
      overflow_q    <= 1'b0;
      acc_q         <= '0;
      acc_ovf_q     <= 1'b0;
      grp_cnt_q     <= '0;
      out_valid_q   <= 1'b0;
    end else begin
      count_q       <= count_d;
      almost_full_q <= (count_d >= CW'(AFT));
      if (wr_en) begin
        wr_ptr_q <= ptr_inc(wr_ptr_q);
      end
      if (drop) begin
        overflow_q <= 1'b1;
      end
      if (handshake) begin
        state_q     <= ACCUM;
        out_valid_q <= 1'b0;
      end
      if (pop) begin
        rd_ptr_q <= ptr_inc(rd_ptr_q);
        if (grp_cnt_q == '0) begin
          len_q <= len_now;
        end
        if (grp_last) begin
          out_data_q  <= sum[ACC_WIDTH-1:0];
          out_ovf_q   <= acc_ovf_q | sum[ACC_WIDTH];
          acc_q       <= '0;
          acc_ovf_q   <= 1'b0;
          grp_cnt_q   <= '0;
          state_q     <= HOLD;
          out_valid_q <= 1'b1;
        end else begin
          acc_q     <= sum[ACC_WIDTH-1:0];
          acc_ovf_q <= acc_ovf_q | sum[ACC_WIDTH];
          grp_cnt_q <= grp_cnt_q + LW'(1);
        end
      end
    end
  end

  assign almost_full = almost_full_q;
  assign fifo_count  = count_q;
  assign overflow    = overflow_q;
  assign out_data    = out_data_q;
  assign out_ovf     = out_ovf_q;
  assign out_valid   = out_valid_q;

endmodule

// File: tb/tb_mac_result_accumulator.sv
// Directed bench for mac_result_accumulator with a result scoreboard.
module tb_mac_result_accumulator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        clear = 1'b0;
  logic [15:0] len = 16'd1;
  logic [15:0] in_data = '0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        almost_full;
  logic [3:0]  fifo_count;
  logic        overflow;
  logic [31:0] out_data;
  logic        out_ovf;
  logic        out_valid;

  logic [15:0] len16 = 16'd2;
  logic [15:0] in16_data = '0;
  logic        in16_valid = 1'b0;
  logic        clear16 = 1'b0;
  logic        ready16 = 1'b1;
  logic        af16;
  logic [3:0]  cnt16;
  logic        ovfl16;
  logic [15:0] out16_data;
  logic        out16_ovf;
  logic        out16_valid;

  typedef struct packed {
    logic [31:0] data;
    logic        ovf;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  mac_result_accumulator u_dut (
    .clk(clk), .rst(rst), .clear(clear), .len(len),
    .in_data(in_data), .in_valid(in_valid),
    .almost_full(almost_full), .fifo_count(fifo_count), .overflow(overflow),
    .out_data(out_data), .out_ovf(out_ovf), .out_valid(out_valid),
    .out_ready(out_ready)
  );

  mac_result_accumulator #(.WIDTH(16), .ACC_WIDTH(16)) u_dut16 (
    .clk(clk), .rst(rst), .clear(clear16), .len(len16),
    .in_data(in16_data), .in_valid(in16_valid),
    .almost_full(af16), .fifo_count(cnt16), .overflow(ovfl16),
    .out_data(out16_data), .out_ovf(out16_ovf), .out_valid(out16_valid),
    .out_ready(ready16)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic o);
    exp_t e;
    e.data = d;
    e.ovf  = o;
    sb.push_back(e);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    for (int i = 0; i < budget && sb.size() != 0; i++) tick();
    chk(tag, 64'(sb.size()), 64'd0);
  endtask

  // Scoreboard monitor: a result is consumed where valid and ready meet.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        chk("sb_has_entry", 64'd0, 64'd1);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", 64'(out_data), 64'(e.data));
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
    end
  end

  initial begin
    int exp_cnt;

    // Reset values
    tick();
    tick();
    chk("rst_fifo_count", 64'(fifo_count), 64'd0);
    chk("rst_almost_full", 64'(almost_full), 64'd0);
    chk("rst_overflow", 64'(overflow), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_data", 64'(out_data), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;
    tick();

    // Group of four with latency and single-cycle pulse
    len = 16'd4;
    out_ready = 1'b1;
    push(32'd10, 1'b0);
    in_valid = 1'b1; in_data = 16'd1; tick();
    in_data = 16'd2; tick();
    in_data = 16'd3; tick();
    in_data = 16'd4; tick();
    in_valid = 1'b0;
    chk("lat_not_yet", 64'(out_valid), 64'd0);
    tick();
    chk("lat_valid", 64'(out_valid), 64'd1);
    chk("lat_data", 64'(out_data), 64'd10);
    tick();
    chk("lat_pulse_end", 64'(out_valid), 64'd0);
    wait_drain("drain_len4", 10);

    // len=0 acts as 1
    len = 16'd0;
    push(32'd7, 1'b0);
    in_valid = 1'b1; in_data = 16'd7; tick();
    in_valid = 1'b0;
    wait_drain("drain_len0", 10);

    // len held from first pop of a group
    len = 16'd3;
    push(32'd6, 1'b0);
    in_valid = 1'b1; in_data = 16'd1; tick();
    in_data = 16'd2; tick();
    len = 16'd1;
    in_data = 16'd3; tick();
    in_valid = 1'b0;
    wait_drain("drain_len_hold", 10);

    // Fill while held, almost_full threshold, overflow on tenth write
    out_ready = 1'b0;
    len = 16'd1;
    for (int i = 1; i <= 10; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(i);
      if (i <= 9) push(32'(i), 1'b0);
      tick();
      exp_cnt = (i == 1) ? 1 : ((i - 1 > 8) ? 8 : i - 1);
      chk($sformatf("fill_count_%0d", i), 64'(fifo_count), 64'(exp_cnt));
      chk($sformatf("fill_af_%0d", i), 64'(almost_full), 64'(exp_cnt >= 3));
      chk($sformatf("fill_ovf_%0d", i), 64'(overflow), 64'(i == 10));
    end
    in_valid = 1'b0;
    chk("hold_valid", 64'(out_valid), 64'd1);
    chk("hold_data", 64'(out_data), 64'd1);
    tick();
    chk("hold_stable", 64'(out_data), 64'd1);
    out_ready = 1'b1;
    wait_drain("drain_fill", 20);
    chk("ovf_sticky", 64'(overflow), 64'd1);

    // clear takes priority over a concurrent write
    clear = 1'b1; in_valid = 1'b1; in_data = 16'd99; tick();
    clear = 1'b0; in_valid = 1'b0;
    chk("clr_overflow", 64'(overflow), 64'd0);
    chk("clr_count", 64'(fifo_count), 64'd0);
    chk("clr_af", 64'(almost_full), 64'd0);

    // clear flushes a pending result and buffered words
    out_ready = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      in_data = 16'(50 + i);
      tick();
    end
    in_valid = 1'b0;
    chk("pend_count", 64'(fifo_count), 64'd2);
    chk("pend_valid", 64'(out_valid), 64'd1);
    clear = 1'b1; tick();
    clear = 1'b0;
    chk("flush_count", 64'(fifo_count), 64'd0);
    chk("flush_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    tick(); tick();
    chk("flush_no_out", 64'(out_valid), 64'd0);

    // Full FIFO with simultaneous write and pop
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      in_valid = 1'b1;
      in_data  = 16'(16'h11 + i);
      push(32'(16'h11 + i), 1'b0);
      tick();
    end
    chk("full_count", 64'(fifo_count), 64'd8);
    in_data = 16'h1a;
    push(32'h1a, 1'b0);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wp_count", 64'(fifo_count), 64'd8);
    chk("wp_overflow", 64'(overflow), 64'd0);
    out_ready = 1'b1;
    wait_drain("drain_wp", 20);

    // Reset mid-group abandons partial data
    len = 16'd4;
    in_valid = 1'b1; in_data = 16'd100; tick();
    in_data = 16'd200; tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(fifo_count), 64'd0);
    tick();
    rst = 1'b0;
    tick();
    push(32'd20, 1'b0);
    in_valid = 1'b1; in_data = 16'd5;
    for (int i = 0; i < 4; i++) tick();
    in_valid = 1'b0;
    wait_drain("drain_after_rst", 10);

    // 16-bit accumulator wrap and carry flag, then flag clears per group
    in16_valid = 1'b1; in16_data = 16'hffff; tick();
    in16_data = 16'h0002; tick();
    in16_valid = 1'b0;
    for (int i = 0; i < 10 && !out16_valid; i++) tick();
    chk("w16_valid", 64'(out16_valid), 64'd1);
    chk("w16_data", 64'(out16_data), 64'h0001);
    chk("w16_ovf", 64'(out16_ovf), 64'd1);
    tick();
    in16_valid = 1'b1; in16_data = 16'h0001; tick();
    tick();
    in16_valid = 1'b0;
    for (int i = 0; i < 10 && !out16_valid; i++) tick();
    chk("w16b_valid", 64'(out16_valid), 64'd1);
    chk("w16b_data", 64'(out16_data), 64'h0002);
    chk("w16b_ovf", 64'(out16_ovf), 64'd0);

    tick();
    chk("sb_empty_end", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
